// File: rtl/keypad_scan_16bit.sv
// 4x4 matrix keypad scanner: one column driven low at a time, rows sampled
// through a 2-flop synchronizer, whole-frame debounce, and a 16-bit hex
// entry register that shifts in each accepted digit at the low nibble.
module keypad_scan_16bit #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ROW,
    input  logic        CLR,
    output logic [3:0]  COL,
    output logic [15:0] VALUE,
    output logic [3:0]  KEY,
    output logic        KEY_VALID,
    output logic        KEY_HELD
);

    localparam int             DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]     DEB_TARGET = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Frame bit i corresponds to column i/4, row i%4.
    function automatic logic [3:0] key_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h4;
            4'd2:    code = 4'h7;
            4'd3:    code = 4'h0;
            4'd4:    code = 4'h2;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h8;
            4'd7:    code = 4'hF;
            4'd8:    code = 4'h3;
            4'd9:    code = 4'h6;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hE;
            4'd12:   code = 4'hA;
            4'd13:   code = 4'hB;
            4'd14:   code = 4'hC;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]    row_meta_reg;
    logic [3:0]    row_sync_reg;
    logic [1:0]    col_idx_reg;
    logic [DW-1:0] dwell_reg;
    logic          frame_done_reg;
    logic          sample_now;
    logic [15:0]   frame_bits;

    logic [4:0]    bit_count;
    logic [3:0]    hit_idx;
    logic [3:0]    hit_code;
    logic          is_none;
    logic          is_single;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [3:0]    cand_reg, cand_next;
    logic [3:0]    cnt_inc;
    logic          accept;
    logic          held;

    logic          key_valid_reg;
    logic [3:0]    key_reg;
    logic [15:0]   value_reg;

    // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
        end else begin
            row_meta_reg <= ROW;
            row_sync_reg <= row_meta_reg;
        end
    end

    assign sample_now = (dwell_reg == DWELL_LAST);

    // Column dwell timer and column index; frame_done fires after column 3 is captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_idx_reg    <= 2'd0;
            dwell_reg      <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (sample_now) begin
                dwell_reg      <= '0;
                col_idx_reg    <= col_idx_reg + 2'd1;
                frame_done_reg <= (col_idx_reg == 2'd3);
            end else begin
                dwell_reg <= dwell_reg + 1'b1;
            end
        end
    end

    // Per-column capture of the inverted rows and the active-low column drive.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [3:0] bits_reg;

            // Latch this column's rows (1 = pressed) at the end of its dwell.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    bits_reg <= 4'h0;
                end else if (sample_now && (col_idx_reg == 2'(gi))) begin
                    bits_reg <= ~row_sync_reg;
                end
            end

            assign frame_bits[gi*4 +: 4] = bits_reg;
            assign COL[gi]               = (col_idx_reg != 2'(gi));
        end
    endgenerate

    // Classify the completed frame: count pressed bits and locate the last one.
    always_comb begin
        bit_count = 5'd0;
        hit_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_bits[i]) begin
                bit_count = bit_count + 5'd1;
                hit_idx   = 4'(i);
            end
        end
    end

    assign is_none   = (bit_count == 5'd0);
    assign is_single = (bit_count == 5'd1);
    assign hit_code  = key_code(hit_idx);
    assign cnt_inc   = cnt_reg + 4'd1;

    // Debounce FSM state, counter and candidate registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            cand_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
        end
    end

    // Next-state logic; the FSM only moves on frame boundaries.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        if (frame_done_reg) begin
            case (state_reg)
                ST_IDLE: begin
                    if (is_single) begin
                        state_next = ST_CONFIRM;
                        cand_next  = hit_code;
                        cnt_next   = 4'd1;
                    end
                end
                ST_CONFIRM: begin
                    if (is_single && (hit_code == cand_reg)) begin
                        if (cnt_inc == DEB_TARGET) begin
                            state_next = ST_HELD;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (is_none) begin
                        state_next = ST_RELEASE;
                        cnt_next   = 4'd1;
                    end
                end
                default: begin
                    if (is_none) begin
                        if (cnt_inc == DEB_TARGET) begin
                            state_next = ST_IDLE;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        state_next = ST_HELD;
                    end
                end
            endcase
        end
    end

    // Outputs: accept is the CONFIRM->HELD transition; held covers HELD and RELEASE.
    always_comb begin
        accept = frame_done_reg && (state_reg == ST_CONFIRM) && is_single &&
                 (hit_code == cand_reg) && (cnt_inc == DEB_TARGET);
        held   = (state_reg == ST_HELD) || (state_reg == ST_RELEASE);
    end

    // Registered accept pulse, key code and entry value (clear before shift).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_valid_reg <= 1'b0;
            key_reg       <= 4'h0;
            value_reg     <= 16'h0000;
        end else begin
            key_valid_reg <= accept;
            if (accept) begin
                key_reg   <= cand_reg;
                value_reg <= {(CLR ? 12'h000 : value_reg[11:0]), cand_reg};
            end else if (CLR) begin
                value_reg <= 16'h0000;
            end
        end
    end

    assign VALUE     = value_reg;
    assign KEY       = key_reg;
    assign KEY_VALID = key_valid_reg;
    assign KEY_HELD  = held;

endmodule

// File: tb/tb_keypad_scan_16bit.sv
// Directed bench for keypad_scan_16bit with a 16-clock frame
// (SCAN_DIV=4, DEBOUNCE_SCANS=3) and a behavioural keypad matrix.
module tb_keypad_scan_16bit;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int FRAME    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  ROW;
    logic        CLR = 1'b0;
    logic [3:0]  COL;
    logic [15:0] VALUE;
    logic [3:0]  KEY;
    logic        KEY_VALID;
    logic        KEY_HELD;

    logic [15:0] keys = 16'h0000;   // bit c*4+r = key at row r, column c pressed

    int checks = 0;
    int errors = 0;

    keypad_scan_16bit #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ROW(ROW),
        .CLR(CLR),
        .COL(COL),
        .VALUE(VALUE),
        .KEY(KEY),
        .KEY_VALID(KEY_VALID),
        .KEY_HELD(KEY_HELD)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row is pulled low only while a pressed key's column is driven low.
    always_comb begin
        ROW = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[c*4 + r] && !COL[c]) ROW[r] = 1'b0;
            end
        end
    end

    function automatic logic [15:0] key_mask(input logic [3:0] code);
        logic [15:0] m;
        case (code)
            4'h1: m = 16'h0001;  // r0 c0
            4'h4: m = 16'h0002;  // r1 c0
            4'h7: m = 16'h0004;  // r2 c0
            4'h0: m = 16'h0008;  // r3 c0
            4'h2: m = 16'h0010;  // r0 c1
            4'h5: m = 16'h0020;  // r1 c1
            4'h8: m = 16'h0040;  // r2 c1
            4'hF: m = 16'h0080;  // r3 c1
            4'h3: m = 16'h0100;  // r0 c2
            4'h6: m = 16'h0200;  // r1 c2
            4'h9: m = 16'h0400;  // r2 c2
            4'hE: m = 16'h0800;  // r3 c2
            4'hA: m = 16'h1000;  // r0 c3
            4'hB: m = 16'h2000;  // r1 c3
            4'hC: m = 16'h4000;  // r2 c3
            default: m = 16'h8000; // D: r3 c3
        endcase
        return m;
    endfunction

    // Stop at the falling edge just after column 0 becomes active.
    task automatic align_frame();
        logic [3:0] prev;
        prev = COL;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && COL == 4'b1110) return;
            prev = COL;
        end
        checks++;
        errors++;
        $display("FAIL align_frame: COL=%b, no frame start within 40 clocks", COL);
    endtask

    // Press mask from a frame start for on_frames, release for off_frames, observe pulses.
    task automatic run_key(input logic [15:0] mask, input int on_frames, input int off_frames,
                           output int pulses, output int pulse_n,
                           output logic held_at_pulse, output int held_fall_n);
        pulses        = 0;
        pulse_n       = -1;
        held_at_pulse = 1'b0;
        held_fall_n   = -1;
        align_frame();
        keys = mask;
        for (int n = 1; n <= (on_frames + off_frames) * FRAME + 2; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (KEY_VALID) begin
                pulses++;
                if (pulse_n < 0) begin
                    pulse_n       = n;
                    held_at_pulse = KEY_HELD;
                end
            end
            if (pulse_n >= 0 && held_fall_n < 0 && !KEY_HELD) held_fall_n = n;
            if (n == on_frames * FRAME) keys = 16'h0000;
        end
        keys = 16'h0000;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (COL !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", COL); end
        checks++;
        if (VALUE !== 16'h0000) begin errors++; $display("FAIL reset_value: got %h expected 0000", VALUE); end
        checks++;
        if (KEY_VALID !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", KEY_VALID); end
        checks++;
        if (KEY_HELD !== 1'b0) begin errors++; $display("FAIL reset_key_held: got %b expected 0", KEY_HELD); end
        checks++;
        if (KEY !== 4'h0) begin errors++; $display("FAIL reset_key: got %h expected 0", KEY); end
        rst_n = 1'b1;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            checks++;
            if (COL !== exp_col) begin
                errors++;
                $display("FAIL col_sequence[%0d]: got %b expected %b", k, COL, exp_col);
            end
        end
        $display("test_reset: done, errors so far %0d", errors);
    endtask

    task automatic test_press5();
        int p, pn, fall;
        logic hp;
        run_key(key_mask(4'h5), 6, 4, p, pn, hp, fall);
        checks++;
        if (p !== 1) begin errors++; $display("FAIL press5_pulses: got %0d expected 1", p); end
        checks++;
        if (pn !== 49) begin errors++; $display("FAIL press5_pulse_time: got clock %0d expected 49", pn); end
        checks++;
        if (hp !== 1'b1) begin errors++; $display("FAIL press5_held_at_pulse: got %b expected 1", hp); end
        checks++;
        if (KEY !== 4'h5) begin errors++; $display("FAIL press5_key: got %h expected 5", KEY); end
        checks++;
        if (VALUE !== 16'h0005) begin errors++; $display("FAIL press5_value: got %h expected 0005", VALUE); end
        checks++;
        if (fall !== 145) begin errors++; $display("FAIL press5_held_fall: got clock %0d expected 145", fall); end
        $display("test_press5: pulses=%0d at=%0d KEY=%h VALUE=%h", p, pn, KEY, VALUE);
    endtask

    task automatic enter_digits(input logic [15:0] digits, output int total);
        int p, pn, fall;
        logic hp;
        total = 0;
        for (int d = 3; d >= 0; d--) begin
            run_key(key_mask(digits[d*4 +: 4]), 4, 4, p, pn, hp, fall);
            total += p;
        end
    endtask

    task automatic test_entry();
        int total, p, pn, fall;
        logic hp;
        enter_digits(16'h12AF, total);
        checks++;
        if (total !== 4) begin errors++; $display("FAIL entry_pulses: got %0d expected 4", total); end
        checks++;
        if (VALUE !== 16'h12AF) begin errors++; $display("FAIL entry_value: got %h expected 12AF", VALUE); end
        checks++;
        if (KEY !== 4'hF) begin errors++; $display("FAIL entry_key: got %h expected F", KEY); end
        run_key(key_mask(4'h3), 4, 4, p, pn, hp, fall);
        checks++;
        if (p !== 1) begin errors++; $display("FAIL entry3_pulses: got %0d expected 1", p); end
        checks++;
        if (VALUE !== 16'h2AF3) begin errors++; $display("FAIL entry3_value: got %h expected 2AF3", VALUE); end
        $display("test_entry: VALUE=%h", VALUE);
    endtask

    task automatic test_bounce();
        int p, pn, fall;
        logic hp;
        run_key(key_mask(4'h7), 2, 4, p, pn, hp, fall);
        checks++;
        if (p !== 0) begin errors++; $display("FAIL bounce_pulses: got %0d expected 0", p); end
        checks++;
        if (VALUE !== 16'h2AF3) begin errors++; $display("FAIL bounce_value: got %h expected 2AF3", VALUE); end
        checks++;
        if (KEY !== 4'h3) begin errors++; $display("FAIL bounce_key: got %h expected 3", KEY); end
        checks++;
        if (KEY_HELD !== 1'b0) begin errors++; $display("FAIL bounce_held: got %b expected 0", KEY_HELD); end
        $display("test_bounce: pulses=%0d VALUE=%h", p, VALUE);
    endtask

    task automatic test_multi();
        int p, pn, fall;
        logic hp;
        run_key(key_mask(4'h1) | key_mask(4'h2), 6, 4, p, pn, hp, fall);
        checks++;
        if (p !== 0) begin errors++; $display("FAIL multi_pulses: got %0d expected 0", p); end
        checks++;
        if (VALUE !== 16'h2AF3) begin errors++; $display("FAIL multi_value: got %h expected 2AF3", VALUE); end
        $display("test_multi: pulses=%0d VALUE=%h", p, VALUE);
    endtask

    task automatic test_multi_hold();
        int p, pn;
        p  = 0;
        pn = -1;
        align_frame();
        keys = key_mask(4'h4);
        for (int n = 1; n <= 3 * 64 + 2; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (KEY_VALID) begin
                p++;
                if (pn < 0) pn = n;
            end
            if (n == 64)  keys = key_mask(4'h4) | key_mask(4'h6);
            if (n == 128) keys = 16'h0000;
        end
        checks++;
        if (p !== 1) begin errors++; $display("FAIL multi_hold_pulses: got %0d expected 1", p); end
        checks++;
        if (pn !== 49) begin errors++; $display("FAIL multi_hold_time: got clock %0d expected 49", pn); end
        checks++;
        if (KEY !== 4'h4) begin errors++; $display("FAIL multi_hold_key: got %h expected 4", KEY); end
        checks++;
        if (VALUE !== 16'hAF34) begin errors++; $display("FAIL multi_hold_value: got %h expected AF34", VALUE); end
        checks++;
        if (KEY_HELD !== 1'b0) begin errors++; $display("FAIL multi_hold_held: got %b expected 0", KEY_HELD); end
        $display("test_multi_hold: pulses=%0d KEY=%h VALUE=%h", p, KEY, VALUE);
    endtask

    task automatic test_clr();
        int total;
        enter_digits(16'h12AF, total);
        checks++;
        if (VALUE !== 16'h12AF) begin errors++; $display("FAIL clr_pre_value: got %h expected 12AF", VALUE); end
        CLR = 1'b1;
        @(posedge clk);
        @(negedge clk);
        CLR = 1'b0;
        checks++;
        if (VALUE !== 16'h0000) begin errors++; $display("FAIL clr_value: got %h expected 0000", VALUE); end
        $display("test_clr: VALUE=%h", VALUE);
    endtask

    task automatic test_clr_accept();
        int p, pn, fall;
        logic hp;
        run_key(key_mask(4'hC), 4, 4, p, pn, hp, fall);
        checks++;
        if (VALUE !== 16'h000C) begin errors++; $display("FAIL clr_accept_pre: got %h expected 000C", VALUE); end
        p = 0;
        align_frame();
        keys = key_mask(4'hB);
        for (int n = 1; n <= 8 * FRAME + 2; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (KEY_VALID) p++;
            if (n == 49) begin
                CLR = 1'b0;
                checks++;
                if (KEY_VALID !== 1'b1) begin errors++; $display("FAIL clr_accept_valid: got %b expected 1", KEY_VALID); end
                checks++;
                if (VALUE !== 16'h000B) begin errors++; $display("FAIL clr_accept_value: got %h expected 000B", VALUE); end
                checks++;
                if (KEY !== 4'hB) begin errors++; $display("FAIL clr_accept_key: got %h expected B", KEY); end
            end
            if (n == 48) CLR = 1'b1;
            if (n == 4 * FRAME) keys = 16'h0000;
        end
        CLR = 1'b0;
        checks++;
        if (p !== 1) begin errors++; $display("FAIL clr_accept_pulses: got %0d expected 1", p); end
        $display("test_clr_accept: VALUE=%h", VALUE);
    endtask

    task automatic test_reset_mid_debounce();
        int p;
        align_frame();
        keys = key_mask(4'h8);
        repeat (40) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        keys = 16'h0000;
        checks++;
        if (VALUE !== 16'h0000) begin errors++; $display("FAIL rst_mid_value: got %h expected 0000", VALUE); end
        checks++;
        if (KEY !== 4'h0) begin errors++; $display("FAIL rst_mid_key: got %h expected 0", KEY); end
        checks++;
        if (COL !== 4'b1110) begin errors++; $display("FAIL rst_mid_col: got %b expected 1110", COL); end
        rst_n = 1'b1;
        p = 0;
        for (int n = 0; n < 5 * FRAME; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (KEY_VALID) p++;
        end
        checks++;
        if (p !== 0) begin errors++; $display("FAIL rst_mid_pulses: got %0d expected 0", p); end
        checks++;
        if (KEY_HELD !== 1'b0) begin errors++; $display("FAIL rst_mid_held: got %b expected 0", KEY_HELD); end
        $display("test_reset_mid_debounce: pulses=%0d VALUE=%h", p, VALUE);
    endtask

    initial begin
        test_reset();
        test_press5();
        test_entry();
        test_bounce();
        test_multi();
        test_multi_hold();
        test_clr();
        test_clr_accept();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
